// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared defaults and FSM state encoding for the data cache
package cache_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LINES  = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_FLUSH   = 2'd3
  } cache_state_t;

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - direct-mapped valid/tag/data storage, async read, one write port
module cache_line_array #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx] <= 1'b0;
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES  = DEF_LINES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              flush,
  output logic              flush_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  cache_state_t      state;
  logic [IDX_W-1:0]  flush_idx;
  logic              wr_hit;
  logic              lk_valid;
  logic [TAG_W-1:0]  lk_tag;
  logic [DATA_W-1:0] lk_data;
  logic              hit;
  logic              arr_wr_en;
  logic [DATA_W-1:0] arr_wr_data;

  assign hit = lk_valid && (lk_tag == addr[ADDR_W-1:IDX_W]);

  // Fills and write-hit updates land on the m_ack edge, addressed by the held m_addr.
  assign arr_wr_en   = m_ack && ((state == ST_RD_MISS) || (state == ST_WR_THRU && wr_hit));
  assign arr_wr_data = (state == ST_RD_MISS) ? m_rdata : m_wdata;

  cache_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_lines (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (addr[IDX_W-1:0]),
    .rd_valid(lk_valid),
    .rd_tag  (lk_tag),
    .rd_data (lk_data),
    .wr_en   (arr_wr_en),
    .wr_idx  (m_addr[IDX_W-1:0]),
    .wr_tag  (m_addr[ADDR_W-1:IDX_W]),
    .wr_data (arr_wr_data),
    .clr_en  (state == ST_FLUSH),
    .clr_idx (flush_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      flush_idx  <= '0;
      wr_hit     <= 1'b0;
      ready      <= 1'b0;
      flush_done <= 1'b0;
      rdata      <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      ready      <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state     <= ST_FLUSH;
            flush_idx <= '0;
          end else if (req && !ready) begin
            // Counters saturate at all-ones rather than wrapping.
            if (hit) begin
              if (~&hit_cnt) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              if (~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
            end
            if (we) begin
              state   <= ST_WR_THRU;
              m_req   <= 1'b1;
              m_we    <= 1'b1;
              m_addr  <= addr;
              m_wdata <= wdata;
              wr_hit  <= hit;
            end else if (hit) begin
              ready <= 1'b1;
              rdata <= lk_data;
            end else begin
              state  <= ST_RD_MISS;
              m_req  <= 1'b1;
              m_we   <= 1'b0;
              m_addr <= addr;
            end
          end
        end
        ST_RD_MISS: begin
          if (m_ack) begin
            state <= ST_IDLE;
            m_req <= 1'b0;
            ready <= 1'b1;
            rdata <= m_rdata;
          end
        end
        ST_WR_THRU: begin
          if (m_ack) begin
            state <= ST_IDLE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            ready <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_idx == IDX_W'(LINES - 1)) begin
            state      <= ST_IDLE;
            flush_done <= 1'b1;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - scoreboard bench for data_cache against an address-keyed cache model
module tb_data_cache;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, we, flush;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata, m_wdata, m_rdata;
  logic          ready, flush_done, m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [15:0]   hit_cnt, miss_cnt;

  logic [DW-1:0] s_rdata, s_m_wdata;
  logic          s_ready, s_flush_done, s_m_req, s_m_we;
  logic [AW-1:0] s_m_addr;
  logic [1:0]    s_hit_cnt, s_miss_cnt;

  always #5 clk = ~clk;

  data_cache #(.ADDR_W(AW), .DATA_W(DW), .LINES(LN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .flush(flush), .flush_done(flush_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  data_cache #(.ADDR_W(AW), .DATA_W(DW), .LINES(LN), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(s_rdata), .ready(s_ready), .flush(flush), .flush_done(s_flush_done),
    .m_req(s_m_req), .m_we(s_m_we), .m_addr(s_m_addr), .m_wdata(s_m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: backing memory and the set of cached addresses.
  logic [DW-1:0] mem    [int];
  logic [DW-1:0] cmodel [int];
  int hits = 0;
  int misses = 0;
  int mem_lat = 3;
  bit mem_hold = 1'b0;

  typedef struct { logic is_wr; logic [DW-1:0] data; int hits; int misses; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic is_wr; logic [DW-1:0] wdata; } mexp_t;
  exp_t  sb_q[$];
  mexp_t mem_q[$];

  function automatic logic [DW-1:0] mem_val(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'(a * 40503) ^ 16'h5a5a;
  endfunction

  function automatic void model_fill(input int a, input logic [DW-1:0] d);
    int victims[$];
    foreach (cmodel[k]) if ((k % LN) == (a % LN)) victims.push_back(k);
    foreach (victims[i]) cmodel.delete(victims[i]);
    cmodel[a] = d;
  endfunction

  task automatic issue_expect(input logic w, input int a, input logic [DW-1:0] d, output bit is_hit);
    exp_t  e;
    mexp_t m;
    is_hit = cmodel.exists(a);
    if (is_hit) hits++; else misses++;
    e.is_wr = w; e.hits = hits; e.misses = misses; e.data = '0;
    if (w) begin
      m.addr = 16'(a); m.is_wr = 1'b1; m.wdata = d;
      mem_q.push_back(m);
      mem[a] = d;
      if (is_hit) cmodel[a] = d;
    end else if (is_hit) begin
      e.data = cmodel[a];
    end else begin
      e.data = mem_val(a);
      m.addr = 16'(a); m.is_wr = 1'b0; m.wdata = '0;
      mem_q.push_back(m);
      model_fill(a, e.data);
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (ready) break;
      if (cyc > 200) begin
        checks++; errors++;
        $display("FAIL ready_timeout: got no ready, expected ready within 200 cycles");
        break;
      end
    end
  endtask

  task automatic access(input logic w, input int a, input logic [DW-1:0] d);
    bit h;
    int cyc;
    issue_expect(w, a, d, h);
    req = 1'b1; we = w; addr = 16'(a); wdata = d;
    wait_ready(cyc);
    req = 1'b0; we = 1'b0;
    if (h && !w) chk("hit_latency", cyc, 1);
    @(negedge clk);
  endtask

  task automatic flush_op(input bit with_req, input int a);
    int cyc;
    int c2;
    bit h;
    cmodel.delete();
    flush = 1'b1;
    if (with_req) begin
      issue_expect(1'b0, a, '0, h);
      req = 1'b1; we = 1'b0; addr = 16'(a);
    end
    @(negedge clk);
    cyc = 1;
    flush = 1'b0;
    while (!flush_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("flush_cycles", cyc, 17);
    chk("flush_done_s", s_flush_done, 1);
    @(negedge clk);
    chk("flush_done_pulse", flush_done, 0);
    if (with_req) begin
      wait_ready(c2);
      req = 1'b0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got ready=1, expected no pending request");
      end else begin
        e = sb_q.pop_front();
        if (!e.is_wr) begin
          chk("rdata", rdata, e.data);
          chk("rdata_s", s_rdata, e.data);
        end
        chk("ready_s", s_ready, 1);
        chk("hit_cnt", hit_cnt, e.hits);
        chk("miss_cnt", miss_cnt, e.misses);
        chk("hit_cnt_sat", s_hit_cnt, (e.hits > 3) ? 3 : e.hits);
        chk("miss_cnt_sat", s_miss_cnt, (e.misses > 3) ? 3 : e.misses);
      end
    end
  end

  initial begin : responder
    mexp_t me;
    int lat;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_req && !mem_hold) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_m_req: got m_req=1 addr=0x%0h, expected no memory access", m_addr);
        end else begin
          me = mem_q.pop_front();
          chk("m_addr", m_addr, me.addr);
          chk("m_we", m_we, me.is_wr);
          chk("m_addr_s", s_m_addr, me.addr);
          chk("m_we_s", s_m_we, me.is_wr);
          if (me.is_wr) begin
            chk("m_wdata", m_wdata, me.wdata);
            chk("m_wdata_s", s_m_wdata, me.wdata);
          end
        end
        lat = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          chk("m_req_held", m_req, 1);
        end
        m_rdata = m_we ? '0 : mem_val(int'(m_addr));
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        m_rdata = 16'($urandom);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; flush = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[16'h0023] = 16'hBEEF;
    mem[16'h0013] = 16'h1234;
    mem_lat = 3;

    access(1'b0, 16'h0023, '0);
    chk("s1_miss_rdata", rdata, 16'hBEEF);
    chk("s1_miss_cnt", miss_cnt, 1);
    access(1'b0, 16'h0023, '0);
    chk("s1_hit_rdata", rdata, 16'hBEEF);
    chk("s1_hit_cnt", hit_cnt, 1);

    access(1'b0, 16'h0013, '0);
    chk("s2_conflict_rdata", rdata, 16'h1234);
    access(1'b0, 16'h0023, '0);
    chk("s2_remiss_cnt", miss_cnt, 3);

    access(1'b1, 16'h0023, 16'h5555);
    access(1'b0, 16'h0023, '0);
    chk("s3_wr_hit_rdata", rdata, 16'h5555);
    access(1'b1, 16'h0040, 16'hAAAA);
    access(1'b0, 16'h0040, '0);
    chk("s3_wr_miss_rdata", rdata, 16'hAAAA);
    chk("s3_hit_cnt", hit_cnt, 3);
    chk("s3_miss_cnt", miss_cnt, 5);

    access(1'b0, 16'h0005, '0);
    flush_op(1'b1, 16'h0023);
    chk("s4_post_flush_miss", miss_cnt, 7);

    mem_hold = 1'b1;
    req = 1'b1; we = 1'b0; addr = 16'h0077;
    cyc = 0;
    while (!m_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("s5_m_req_before_rst", m_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_m_req_async", m_req, 0);
    chk("s5_ready", ready, 0);
    chk("s5_hit_cnt", hit_cnt, 0);
    chk("s5_miss_cnt", miss_cnt, 0);
    req = 1'b0;
    cmodel.delete();
    hits = 0;
    misses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);

    access(1'b0, 16'h0023, '0);
    for (int i = 0; i < 5; i++) access(1'b0, 16'h0023, '0);
    chk("s6_sat_hit_cnt", s_hit_cnt, 3);
    chk("s6_full_hit_cnt", hit_cnt, 5);

    mem_lat = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0)
        flush_op(bit'($urandom_range(0, 1)), int'($urandom_range(0, 47)));
      else
        access(logic'($urandom_range(0, 2) == 0), int'($urandom_range(0, 47)), 16'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter ADDR_W, default 16, CPU/memory address width in bits.
REQ-002 Parameter DATA_W, default 16, data word width in bits.
REQ-003 Parameter LINES, default 16, number of one-word direct-mapped lines; power of 2, at least 2.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req  in  1  CPU access request; held high until ready.
REQ-008 we  in  1  CPU write enable, qualified by req.
REQ-009 addr  in  ADDR_W  CPU word address.
REQ-010 wdata  in  DATA_W  CPU write data.
REQ-011 rdata  out  DATA_W  read data, valid when ready=1 and we=0.
REQ-012 ready  out  1  one-cycle completion pulse for the current request.
REQ-013 flush  in  1  invalidate-all command, sampled only in IDLE.
REQ-014 flush_done  out  1  one-cycle pulse when invalidation completes.
REQ-015 m_req / m_we  out  1 / 1  backing-memory request and write strobe.
REQ-016 m_addr / m_wdata  out  ADDR_W / DATA_W  backing-memory address and write data.
REQ-017 m_rdata / m_ack  in  DATA_W / 1  backing-memory read data; one-cycle completion strobe.
REQ-018 hit_cnt / miss_cnt  out  CNT_W / CNT_W  statistics counters.

Function
REQ-019 Address split: index = addr[log2(LINES)-1:0]; tag = the remaining upper bits; each line stores valid, tag and data.
REQ-020 The FSM has four states: IDLE, RD_MISS, WR_THRU, FLUSH.
REQ-021 Priority in IDLE: flush=1 moves to FLUSH with index counter 0, and any req is not accepted that cycle; otherwise req is accepted.
REQ-022 Read hit, accepted in IDLE: the next cycle drives ready=1 and rdata=line data, stays in IDLE, and increments hit_cnt.
REQ-023 Read miss: the FSM enters RD_MISS and holds m_req=1, m_we=0, m_addr=addr until the cycle m_ack=1 is sampled.
REQ-024 On that m_ack edge, the line is written (valid=1, tag, data=m_rdata), the FSM returns to IDLE, and the next cycle drives ready=1 and rdata=filled data.
REQ-025 Write, accepted in IDLE: the FSM enters WR_THRU and holds m_req=1, m_we=1, m_addr=addr, m_wdata=wdata until m_ack; ready=1 follows in the cycle after m_ack.
REQ-026 Write policy: write-through, no-write-allocate. On a tag hit the line data is updated on the m_ack edge; on a miss the line is left untouched.
REQ-027 A write counts as a hit or a miss by its tag lookup at acceptance.
REQ-028 A read miss increments miss_cnt on acceptance.
REQ-029 Both counters saturate at all-ones and never wrap.
REQ-030 FLUSH clears one valid bit per cycle, index 0..LINES-1. flush_done pulses in the cycle after index LINES-1 is cleared, and the FSM returns to IDLE; LINES+1 cycles total.
REQ-031 A req held during FLUSH is accepted only once the FSM is back in IDLE.
REQ-032 The FSM never accepts a new req in the ready cycle itself; back-to-back accesses take at least 2 cycles each.
REQ-033 flush and m_ack asserted outside their qualifying states are ignored.
REQ-034 m_req is never asserted in IDLE or FLUSH.

Reset
REQ-035 On reset=0, all of the following clear immediately: all valid bits, FSM to IDLE, ready=0, flush_done=0, m_req=0, m_we=0, hit_cnt=0, miss_cnt=0, flush index=0.
REQ-036 Tag and data arrays are not reset; reset mid-miss or mid-flush abandons the operation with no ready.
REQ-037 rdata, m_addr and m_wdata reset to 0.

Structure
REQ-038 Shared package cache_pkg holds the FSM state encoding and the default parameter values.
REQ-039 The storage array is a single sub-module, cache_line_array (valid/tag/data, one read port, one write port, per-index valid clear, asynchronous valid reset).

Verification
REQ-040 Scenario: read miss then hit. Read 0x0023 with memory returning 0xBEEF after 3 cycles gives ready with rdata=0xBEEF and miss_cnt=1. Re-reading 0x0023 gives ready next cycle with 0xBEEF, hit_cnt=1, and no m_req.
REQ-041 Scenario: conflict. After 0x0023 is cached, reading 0x0013 (same index, other tag) is a miss. Memory returns 0x1234, then reading 0x0023 misses again.
REQ-042 Scenario: write hit versus write miss. A write of 0x5555 to cached 0x0023 makes one memory write with m_wdata=0x5555, and a later read hits with 0x5555. A write to uncached 0x0040 followed by a read of 0x0040 is a miss.
REQ-043 Scenario: flush. With 3 lines valid and req high, flush=1 gives flush_done 17 cycles later (LINES=16). The held req is then accepted and misses.
REQ-044 Scenario: reset during RD_MISS before m_ack drops m_req asynchronously with no ready, and hit_cnt=miss_cnt=0.
REQ-045 Scenario: saturation. With CNT_W=2, five read hits leave hit_cnt=3.
